// File: rtl/elbeth_mem_arbiter_if.sv
// Request/response bundle shared by imem, dmem and the memory side.
// The requester drives en/addr/rw/wdata; the responder returns rdata/ready/error.
interface elbeth_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0]            rw;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  error;

   modport master (
      output en, addr, rw, wdata,
      input  rdata, ready, error
   );

   modport slave (
      input  en, addr, rw, wdata,
      output rdata, ready, error
   );
endinterface

// File: rtl/elbeth_mem_arbiter.sv
// Shares one single-port memory between the imem and dmem ports of elbeth_core.
// One access at a time, latched command, watchdog abort on a stuck memory.
module elbeth_mem_arbiter #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int ROUND_ROBIN = 0,
   parameter int TIMEOUT     = 255
) (
   input logic clk,
   input logic rst,
   elbeth_mem_arbiter_if.slave  imem,
   elbeth_mem_arbiter_if.slave  dmem,
   elbeth_mem_arbiter_if.master mem
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } state_t;

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic                  en_q, en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            rw_q, rw_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  pick_d;
   logic                  timeout;
   logic                  done;
   logic                  i_done;
   logic                  d_done;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   // last_q=1 means dmem held the most recent grant
   assign pick_d  = dmem.en &&
                    (!imem.en || (ROUND_ROBIN == 0) || !last_q);
   assign timeout = (TIMEOUT != 0) &&
                    (wd_q == WD_W'(TIMEOUT - 1));
   assign done    = (state_q != IDLE) && (mem.ready || timeout);
   assign i_done  = done && (state_q == BUSY_I);
   assign d_done  = done && (state_q == BUSY_D);

   // a real completion beats a simultaneous watchdog abort
   assign rsp_rdata = mem.ready ? mem.rdata : '0;
   assign rsp_err   = mem.ready ? mem.error : 1'b1;

   assign imem.ready = i_done;
   assign imem.error = i_done && rsp_err;
   assign imem.rdata = i_done ? rsp_rdata : '0;
   assign dmem.ready = d_done;
   assign dmem.error = d_done && rsp_err;
   assign dmem.rdata = d_done ? rsp_rdata : '0;

   assign mem.en    = en_q;
   assign mem.addr  = addr_q;
   assign mem.rw    = rw_q;
   assign mem.wdata = wdata_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wd_d    = wd_q;
      en_d    = en_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (imem.en || dmem.en) begin
               en_d = 1'b1;
               wd_d = '0;
               if (pick_d) begin
                  state_d = BUSY_D;
                  last_d  = 1'b1;
                  addr_d  = dmem.addr;
                  rw_d    = dmem.rw;
                  wdata_d = dmem.wdata;
               end else begin
                  state_d = BUSY_I;
                  last_d  = 1'b0;
                  addr_d  = imem.addr;
                  rw_d    = imem.rw;
                  wdata_d = imem.wdata;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (done) begin
               state_d = IDLE;
               en_d    = 1'b0;
            end else if (wd_q != WD_W'(TIMEOUT)) begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            en_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         wd_q    <= '0;
         en_q    <= 1'b0;
         addr_q  <= '0;
         rw_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Bench for elbeth_mem_arbiter: two instances (RR=0/TIMEOUT=4, RR=1/no watchdog),
// a behavioural memory per instance and a reference memory image.
module tb_elbeth_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // requester slot j = 2*k + p, k = instance, p: 0 imem, 1 dmem
   logic        r_en   [4];
   logic [7:0]  r_addr [4];
   logic [3:0]  r_rw   [4];
   logic [31:0] r_wd   [4];
   logic [3:0]  rdy;
   logic [3:0]  err;
   logic [31:0] rd     [4];

   logic [1:0]  m_en;
   logic [7:0]  m_addr [2];
   logic [3:0]  m_rw   [2];
   logic [31:0] m_wd   [2];
   logic        m_ready[2];
   logic        m_error[2];
   logic [31:0] m_rdata[2];
   int          lat    [2];

   elbeth_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifr [4] ();
   elbeth_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifm [2] ();

   for (genvar j = 0; j < 4; j++) begin : g_req
      assign ifr[j].en    = r_en[j];
      assign ifr[j].addr  = r_addr[j];
      assign ifr[j].rw    = r_rw[j];
      assign ifr[j].wdata = r_wd[j];
      assign rdy[j]       = ifr[j].ready;
      assign err[j]       = ifr[j].error;
      assign rd[j]        = ifr[j].rdata;
   end

   for (genvar k = 0; k < 2; k++) begin : g_dut
      assign m_en[k]       = ifm[k].en;
      assign m_addr[k]     = ifm[k].addr;
      assign m_rw[k]       = ifm[k].rw;
      assign m_wd[k]       = ifm[k].wdata;
      assign ifm[k].rdata  = m_rdata[k];
      assign ifm[k].ready  = m_ready[k];
      assign ifm[k].error  = m_error[k];
      elbeth_mem_arbiter #(
         .ADDR_WIDTH (AW),
         .DATA_WIDTH (DW),
         .ROUND_ROBIN(k),
         .TIMEOUT    (k == 0 ? 4 : 0)
      ) dut (
         .clk (clk),
         .rst (rst),
         .imem(ifr[2*k]),
         .dmem(ifr[2*k+1]),
         .mem (ifm[k])
      );
   end

   // behavioural memory: ready in the lat-th cycle of mem_en, lat=0 never
   bit   [31:0] phys     [2][256];
   int          cnt      [2];
   logic [7:0]  cap_addr [2];
   logic [3:0]  cap_rw   [2];
   logic [31:0] cap_wd   [2];
   bit          moved    [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_ready[k] = 1'b0;
         m_error[k] = 1'b0;
         m_rdata[k] = '0;
         if (m_en[k] !== 1'b1) begin
            cnt[k] = 0;
         end else begin
            if (cnt[k] == 0) begin
               cap_addr[k] = m_addr[k];
               cap_rw[k]   = m_rw[k];
               cap_wd[k]   = m_wd[k];
               moved[k]    = 1'b0;
            end else if (m_addr[k] !== cap_addr[k] ||
                         m_rw[k] !== cap_rw[k] ||
                         m_wd[k] !== cap_wd[k]) begin
               moved[k] = 1'b1;
            end
            cnt[k]++;
            if (lat[k] != 0 && cnt[k] == lat[k]) begin
               m_ready[k] = 1'b1;
               m_error[k] = (cap_addr[k][7:4] == 4'hF);
               if (cap_rw[k] == 4'b0000)
                  m_rdata[k] = phys[k][cap_addr[k]];
               else if (!m_error[k])
                  for (int b = 0; b < 4; b++)
                     if (cap_rw[k][b])
                        phys[k][cap_addr[k]][8*b +: 8] = cap_wd[k][8*b +: 8];
            end
         end
      end
   end

   // reference image of what memory should hold, updated on completion
   bit   [31:0] ref_mem [2][256];
   logic [7:0]  q_addr  [4];
   logic [3:0]  q_rw    [4];
   logic [31:0] q_wd    [4];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      #2;
   endtask

   task automatic issue(input int k, input int p, input logic [7:0] a,
                        input logic [3:0] rw, input logic [31:0] wd);
      int j = 2 * k + p;
      r_en[j]   = 1'b1;
      r_addr[j] = a;
      r_rw[j]   = rw;
      r_wd[j]   = wd;
      q_addr[j] = a;
      q_rw[j]   = rw;
      q_wd[j]   = wd;
   endtask

   task automatic wait_any(input int k, output int p, output int n);
      p = -1;
      n = 0;
      for (int c = 1; c <= 40 && p < 0; c++) begin
         @(negedge clk);
         #2;
         if (rdy[2*k] || rdy[2*k+1]) begin
            p = rdy[2*k+1] ? 1 : 0;
            n = c;
            chk("single_ready", 32'(rdy[2*k] & rdy[2*k+1]), 32'd0);
            chk("other_rdata", rd[2*k+1-p], 32'd0);
            chk("other_error", 32'(err[2*k+1-p]), 32'd0);
         end
      end
      total++;
      assert (p >= 0) else begin
         bad++;
         $error("FAIL ready_wait: got none want ready on inst %0d", k);
      end
   endtask

   task automatic finish_req(input int k, input int p, input bit hang);
      int          j = 2 * k + p;
      logic [31:0] er;
      logic        ee;
      if (hang) begin
         er = '0;
         ee = 1'b1;
      end else begin
         ee = (q_addr[j][7:4] == 4'hF);
         er = (q_rw[j] == 4'b0000) ? ref_mem[k][q_addr[j]] : 32'd0;
         if (!ee)
            for (int b = 0; b < 4; b++)
               if (q_rw[j][b])
                  ref_mem[k][q_addr[j]][8*b +: 8] = q_wd[j][8*b +: 8];
      end
      chk("rdata", rd[j], er);
      chk("error", 32'(err[j]), 32'(ee));
      chk("mem_addr", 32'(cap_addr[k]), 32'(q_addr[j]));
      chk("mem_rw", 32'(cap_rw[k]), 32'(q_rw[j]));
      chk("mem_wdata", cap_wd[k], q_wd[j]);
      chk("mem_stable", 32'(moved[k]), 32'd0);
      r_en[j] = 1'b0;
   endtask

   initial begin
      int         p, n, last, mode, lt;
      logic [7:0] a, b;
      logic [3:0] rw;
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         r_en[j]   = 1'b0;
         r_addr[j] = '0;
         r_rw[j]   = '0;
         r_wd[j]   = '0;
      end
      lat[0] = 2;
      lat[1] = 2;
      repeat (3) idle();

      for (int k = 0; k < 2; k++) begin
         chk("rst_mem_en", 32'(m_en[k]), 32'd0);
         chk("rst_mem_addr", 32'(m_addr[k]), 32'd0);
         chk("rst_mem_rw", 32'(m_rw[k]), 32'd0);
         chk("rst_mem_wdata", m_wd[k], 32'd0);
      end
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_error", 32'(err), 32'd0);
      for (int j = 0; j < 4; j++) chk("rst_rdata", rd[j], 32'd0);

      rst = 1'b1;
      repeat (2) idle();
      chk("idle_no_grant", 32'(m_en), 32'd0);

      // put DEADBEEF at 0x10, then read it through imem
      issue(0, 1, 8'h10, 4'hF, 32'hDEADBEEF);
      wait_any(0, p, n);
      chk("pre_grant", p, 1);
      finish_req(0, 1, 0);
      idle();
      lat[0] = 3;
      issue(0, 0, 8'h10, 4'h0, 32'h0);
      idle();
      chk("t1_mem_en", 32'(m_en[0]), 32'd1);
      chk("t1_mem_addr", 32'(m_addr[0]), 32'h10);
      wait_any(0, p, n);
      chk("t1_port", p, 0);
      chk("t1_latency", n, 2);
      chk("t1_rdata", rd[0], 32'hDEADBEEF);
      chk("t1_dmem_quiet", 32'(rdy[1]), 32'd0);
      finish_req(0, 0, 0);

      // tie with ROUND_ROBIN=0: dmem first, bubble, then imem
      idle();
      lat[0] = 2;
      a = 8'($urandom_range(0, 200));
      b = a + 8'd7;
      issue(0, 1, a, 4'h0, 32'h0);
      issue(0, 0, b, 4'h0, 32'h0);
      wait_any(0, p, n);
      chk("t2_first", p, 1);
      chk("t2_lat1", n, 2);
      finish_req(0, p, 0);
      wait_any(0, p, n);
      chk("t2_second", p, 0);
      chk("t2_bubble", n, 3);
      finish_req(0, p, 0);

      // ROUND_ROBIN=1, both continuously requesting; watchdog disabled
      idle();
      lat[1] = 6;
      issue(1, 0, 8'($urandom_range(0, 239)), 4'h0, 32'h0);
      issue(1, 1, 8'($urandom_range(0, 239)), 4'hF, $urandom);
      last = 0;
      for (int g = 0; g < 6; g++) begin
         wait_any(1, p, n);
         chk("t3_order", p, (g < 5) ? 1 - last : 1 - last);
         chk("t3_latency", n, (g == 0) ? 6 : 7);
         if (p < 0) break;
         finish_req(1, p, 0);
         last = p;
         if (g < 4)
            issue(1, p, 8'($urandom), 4'($urandom_range(0, 1) * 15), $urandom);
      end

      // latched command survives requester changes mid-BUSY
      idle();
      lat[0] = 4;
      a = 8'($urandom_range(0, 239));
      issue(0, 1, a, 4'b0011, 32'h1234_5678);
      repeat (2) idle();
      r_addr[1] = a ^ 8'h55;
      r_rw[1]   = 4'b1100;
      r_wd[1]   = 32'hA5A5_0F0F;
      wait_any(0, p, n);
      chk("t4_port", p, 1);
      chk("t4_mem_addr", 32'(m_addr[0]), 32'(a));
      chk("t4_mem_rw", 32'(m_rw[0]), 32'b0011);
      chk("t4_mem_wdata", m_wd[0], 32'h1234_5678);
      finish_req(0, 1, 0);
      idle();
      lat[0] = 1;
      issue(0, 0, a, 4'h0, 32'h0);
      wait_any(0, p, n);
      finish_req(0, 0, 0);

      // watchdog abort at the 4th BUSY cycle, then normal service
      idle();
      lat[0] = 0;
      issue(0, 1, 8'($urandom_range(0, 239)), 4'h0, 32'h0);
      wait_any(0, p, n);
      chk("t5_port", p, 1);
      chk("t5_cycles", n, 4);
      finish_req(0, 1, 1);
      idle();
      chk("t5_en_drop", 32'(m_en[0]), 32'd0);
      lat[0] = 2;
      issue(0, 0, 8'($urandom_range(0, 239)), 4'h0, 32'h0);
      wait_any(0, p, n);
      chk("t5_after_port", p, 0);
      chk("t5_after_lat", n, 2);
      finish_req(0, 0, 0);

      // reset in the middle of a write drops it
      idle();
      lat[0] = 10;
      issue(0, 0, 8'h3C, 4'hF, 32'hCAFE_F00D);
      repeat (3) idle();
      rst = 1'b0;
      #1;
      chk("t6_mem_en", 32'(m_en[0]), 32'd0);
      chk("t6_mem_addr", 32'(m_addr[0]), 32'd0);
      chk("t6_mem_rw", 32'(m_rw[0]), 32'd0);
      chk("t6_mem_wdata", m_wd[0], 32'd0);
      chk("t6_ready", 32'(rdy), 32'd0);
      chk("t6_rdata", rd[0], 32'd0);
      r_en[0] = 1'b0;
      idle();
      rst = 1'b1;
      idle();
      lat[0] = 2;
      issue(0, 0, 8'h3C, 4'h0, 32'h0);
      wait_any(0, p, n);
      chk("t6_fresh_lat", n, 2);
      finish_req(0, 0, 0);

      // random single and tied traffic on the fixed-priority instance
      for (int r = 0; r < 25; r++) begin
         idle();
         lt     = $urandom_range(1, 3);
         lat[0] = lt;
         mode   = $urandom_range(0, 2);
         for (int q = 0; q < 2; q++) begin
            if (mode == 2 || mode == q) begin
               rw = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
               issue(0, q, 8'($urandom), rw, $urandom);
            end
         end
         wait_any(0, p, n);
         chk("rnd_first", p, (mode == 0) ? 0 : 1);
         chk("rnd_lat", n, lt);
         if (p >= 0) finish_req(0, p, 0);
         if (mode == 2) begin
            wait_any(0, p, n);
            chk("rnd_second", p, 0);
            chk("rnd_bubble", n, lt + 1);
            if (p >= 0) finish_req(0, p, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
